// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct3/funct7 encodings, ALU operations and helpers.
// Used by the single-cycle core, its register file and the SoC wrapper.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_t;

    // alt selects SUB/SRA; callers must only raise it where funct7[5] is meaningful
    function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu_exec(input alu_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'd0, a < b};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv32i_soc_core.sv
// Single-cycle RV32I integer core: fetch, decode, execute and memory access in one clock.
// Anything outside the base integer subset (FENCE, SYSTEM, unknown) retires as a NOP.
module rv32i_soc_core
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [29:0] fetch_addr,
    input  logic [31:0] instr,
    output logic [29:0] data_word_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_be,
    output logic        data_we,
    input  logic [31:0] data_rdata
);

    logic [31:0] pc, pc_next;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_res;
    logic [31:0] rd_wdata, ld_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        rd_we, ld_ok, st_ok, br_take;
    alu_op_t     alu_op;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    rv32i_soc_regfile m_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .we       (rd_we),
        .rd_addr  (rd),
        .rd_data  (rd_wdata)
    );

    // The ALU also forms load/store addresses and the JALR target (rs1 + imm_i).
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = imm_i;
        case (opcode)
            OPC_OP_IMM: alu_op = alu_decode(funct3, instr[30] && funct3 == F3_SR);
            OPC_OP: begin
                alu_b  = rs2_val;
                alu_op = alu_decode(funct3, instr[30]);
            end
            OPC_STORE:  alu_b = imm_s;
            default:    ;
        endcase
    end

    assign alu_res = alu_exec(alu_op, rs1_val, alu_b);

    always_comb begin
        case (funct3)
            F3_BEQ:  br_take = rs1_val == rs2_val;
            F3_BNE:  br_take = rs1_val != rs2_val;
            F3_BLT:  br_take = $signed(rs1_val) <  $signed(rs2_val);
            F3_BGE:  br_take = $signed(rs1_val) >= $signed(rs2_val);
            F3_BLTU: br_take = rs1_val <  rs2_val;
            F3_BGEU: br_take = rs1_val >= rs2_val;
            default: br_take = 1'b0;
        endcase
    end

    // Sub-word loads ignore the address bits below their natural alignment.
    always_comb begin
        case (alu_res[1:0])
            2'd0:    ld_byte = data_rdata[7:0];
            2'd1:    ld_byte = data_rdata[15:8];
            2'd2:    ld_byte = data_rdata[23:16];
            default: ld_byte = data_rdata[31:24];
        endcase
        ld_half = alu_res[1] ? data_rdata[31:16] : data_rdata[15:0];
        ld_ok   = 1'b1;
        case (funct3)
            F3_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            F3_LW:   ld_val = data_rdata;
            F3_LBU:  ld_val = {24'd0, ld_byte};
            F3_LHU:  ld_val = {16'd0, ld_half};
            default: begin
                ld_val = 32'd0;
                ld_ok  = 1'b0;
            end
        endcase
    end

    always_comb begin
        st_ok = 1'b1;
        case (funct3)
            F3_SB: begin
                data_wdata = {4{rs2_val[7:0]}};
                data_be    = 4'b0001 << alu_res[1:0];
            end
            F3_SH: begin
                data_wdata = {2{rs2_val[15:0]}};
                data_be    = alu_res[1] ? 4'b1100 : 4'b0011;
            end
            F3_SW: begin
                data_wdata = rs2_val;
                data_be    = 4'b1111;
            end
            default: begin
                data_wdata = rs2_val;
                data_be    = 4'b0000;
                st_ok      = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_next  = pc + 32'd4;
        rd_we    = 1'b0;
        rd_wdata = alu_res;
        data_we  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OPC_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc + imm_u;
            end
            OPC_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc + 32'd4;
                pc_next  = pc + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    rd_we    = 1'b1;
                    rd_wdata = pc + 32'd4;
                    pc_next  = alu_res & ~32'd1;
                end
            end
            OPC_BRANCH: if (br_take) pc_next = pc + imm_b;
            OPC_LOAD: begin
                rd_we    = ld_ok;
                rd_wdata = ld_val;
            end
            OPC_STORE:  data_we = st_ok;
            OPC_OP_IMM: rd_we = 1'b1;
            OPC_OP:     rd_we = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) pc <= RESET_PC;
        else       pc <= pc_next;
    end

    assign fetch_addr     = pc[31:2];
    assign data_word_addr = alu_res[31:2];

endmodule

// File: rtl/rv32i_soc_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port at the clock edge.
// x0 is hardwired to zero; a same-cycle read of the written register returns the old value.
module rv32i_soc_regfile
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && rd_addr != 5'd0) begin
            regs[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

endmodule

// File: rtl/rv32i_soc_rom.sv
// Instruction ROM with combinational word read; rom_mem is preloaded by the environment.
// Fetches beyond the array depth return a NOP so a runaway PC just keeps sliding forward.
module rv32i_soc_rom
    import rv32i_pkg::*;
#(
    parameter int ROM_WORDS = 4096
) (
    input  logic [29:0] word_addr,
    output logic [31:0] data
);

    localparam int AW = $clog2(ROM_WORDS);

    logic [31:0] rom_mem [0:ROM_WORDS-1];

    assign data = (word_addr < 30'(ROM_WORDS)) ? rom_mem[word_addr[AW-1:0]] : NOP;

endmodule

// File: rtl/rv32i_soc.sv
// Harvard RV32I system for compliance runs: core, preloaded instruction ROM and byte-enabled data RAM.
// No I/O besides clock and reset; results are observed through the core's register file.
module rv32i_soc
    import rv32i_pkg::*;
#(
    parameter int          ROM_WORDS = 4096,
    parameter int          RAM_WORDS = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst_n
);

    localparam int RAW = $clog2(RAM_WORDS);

    logic [29:0]    fetch_addr, data_word_addr;
    logic [31:0]    instr, data_wdata, data_rdata;
    logic [3:0]     data_be;
    logic           data_we;
    logic [RAW-1:0] ram_idx;
    logic [31:0]    ram_mem [0:RAM_WORDS-1];

    rv32i_soc_core #(.RESET_PC(RESET_PC)) top (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_addr     (fetch_addr),
        .instr          (instr),
        .data_word_addr (data_word_addr),
        .data_wdata     (data_wdata),
        .data_be        (data_be),
        .data_we        (data_we),
        .data_rdata     (data_rdata)
    );

    rv32i_soc_rom #(.ROM_WORDS(ROM_WORDS)) m_rom (
        .word_addr (fetch_addr),
        .data      (instr)
    );

    // Data addresses wrap around the RAM depth rather than faulting.
    assign ram_idx    = RAW'(data_word_addr % 30'(RAM_WORDS));
    assign data_rdata = ram_mem[ram_idx];

    always_ff @(posedge clk) begin
        if (!rst_n && data_we) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be[b]) ram_mem[ram_idx][8*b +: 8] <= data_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_rv32i_soc.sv
// Directed bench for rv32i_soc: hand-assembled programs are poked into the ROM and the
// architectural state (PC, registers) is compared with hand-computed values.
module tb_rv32i_soc;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cycles;
    logic [31:0] prog [$];

    rv32i_soc dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
    endfunction

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic loadProgram();
        for (int i = 0; i < 128; i++)
            dut.m_rom.rom_mem[i] = (i < prog.size()) ? prog[i] : NOP;
    endtask

    task automatic resetDut();
        rst_n = 1'b1;
        applyStimulus(2);
        rst_n = 1'b0;
    endtask

    function automatic logic [31:0] xreg(input int n);
        return dut.top.m_regs.regs[n];
    endfunction

    initial begin
        // Program A: ALU, control flow, memory and unsupported instructions.
        prog = '{
            enc_i(12'hFFF, 5'd0, F3_ADD, 5'd1, OPC_OP_IMM),       // 00 ADDI x1,x0,-1
            enc_i(12'h404, 5'd1, F3_SR, 5'd2, OPC_OP_IMM),        // 04 SRAI x2,x1,4
            enc_r(F7_BASE, 5'd1, 5'd0, F3_SLTU, 5'd3),            // 08 SLTU x3,x0,x1
            enc_r(F7_ALT, 5'd1, 5'd0, F3_ADD, 5'd4),              // 0C SUB x4,x0,x1
            enc_i(12'd5, 5'd0, F3_ADD, 5'd0, OPC_OP_IMM),         // 10 ADDI x0,x0,5
            enc_b(13'd8, 5'd0, 5'd1, F3_BLT),                     // 14 BLT x1,x0,+8
            enc_i(12'd1, 5'd0, F3_ADD, 5'd7, OPC_OP_IMM),         // 18 skipped
            enc_b(13'd8, 5'd0, 5'd1, F3_BLTU),                    // 1C BLTU x1,x0,+8
            enc_i(12'd2, 5'd0, F3_ADD, 5'd8, OPC_OP_IMM),         // 20 ADDI x8,x0,2
            enc_j(21'd8, 5'd5),                                   // 24 JAL x5,+8
            enc_i(12'd3, 5'd0, F3_ADD, 5'd9, OPC_OP_IMM),         // 28 skipped
            enc_i(12'h03C, 5'd0, F3_ADD, 5'd6, OPC_OP_IMM),       // 2C ADDI x6,x0,0x3C
            enc_i(12'd0, 5'd6, 3'b000, 5'd6, OPC_JALR),           // 30 JALR x6,x6,0
            enc_i(12'd4, 5'd0, F3_ADD, 5'd10, OPC_OP_IMM),        // 34 skipped
            enc_i(12'd5, 5'd0, F3_ADD, 5'd10, OPC_OP_IMM),        // 38 skipped
            enc_u(20'h80FF8, 5'd11, OPC_LUI),                     // 3C LUI x11
            enc_i(12'hF01, 5'd11, F3_ADD, 5'd11, OPC_OP_IMM),     // 40 x11 = 80FF7F01
            enc_i(12'h100, 5'd0, F3_ADD, 5'd12, OPC_OP_IMM),      // 44 x12 = 0x100
            enc_s(12'd0, 5'd11, 5'd12, F3_SW),                    // 48 SW
            enc_i(12'd0, 5'd12, F3_LB, 5'd13, OPC_LOAD),          // 4C LB 0x100
            enc_i(12'd3, 5'd12, F3_LB, 5'd14, OPC_LOAD),          // 50 LB 0x103
            enc_i(12'd3, 5'd12, F3_LBU, 5'd15, OPC_LOAD),         // 54 LBU 0x103
            enc_i(12'd2, 5'd12, F3_LH, 5'd16, OPC_LOAD),          // 58 LH 0x102
            enc_i(12'd2, 5'd12, F3_LHU, 5'd17, OPC_LOAD),         // 5C LHU 0x102
            enc_i(12'h022, 5'd0, F3_ADD, 5'd18, OPC_OP_IMM),      // 60 x18 = 0x22
            enc_s(12'd1, 5'd18, 5'd12, F3_SB),                    // 64 SB 0x101
            enc_i(12'd0, 5'd12, F3_LW, 5'd19, OPC_LOAD),          // 68 LW 0x100
            enc_i(12'd1, 5'd12, F3_LH, 5'd22, OPC_LOAD),          // 6C LH 0x101 (misaligned)
            32'h0000_0073,                                        // 70 ECALL
            enc_i(12'h305, 5'd1, 3'b001, 5'd20, 7'h73),           // 74 CSRRW x20,mtvec,x1
            enc_i(12'd7, 5'd0, F3_ADD, 5'd21, OPC_OP_IMM),        // 78 ADDI x21,x0,7
            enc_j(21'd0, 5'd0)                                    // 7C JAL x0,0
        };
        loadProgram();
        resetDut();
        checkOutput("reset_pc", dut.top.pc, 32'h0);
        checkOutput("first_fetch", dut.top.instr, prog[0]);
        checkOutput("reset_x1", xreg(1), 32'h0);

        applyStimulus(4);
        checkOutput("addi_x1", xreg(1), 32'hFFFF_FFFF);
        checkOutput("srai_x2", xreg(2), 32'hFFFF_FFFF);
        checkOutput("sltu_x3", xreg(3), 32'h1);
        checkOutput("sub_x4", xreg(4), 32'h1);
        applyStimulus(1);
        checkOutput("x0_zero", xreg(0), 32'h0);
        applyStimulus(1);
        checkOutput("blt_taken_pc", dut.top.pc, 32'h1C);
        applyStimulus(1);
        checkOutput("bltu_not_taken_pc", dut.top.pc, 32'h20);
        applyStimulus(2);
        checkOutput("jal_pc", dut.top.pc, 32'h2C);
        checkOutput("jal_link_x5", xreg(5), 32'h28);
        applyStimulus(2);
        checkOutput("jalr_pc", dut.top.pc, 32'h3C);
        checkOutput("jalr_link_x6", xreg(6), 32'h34);
        checkOutput("skipped_x7", xreg(7), 32'h0);
        checkOutput("skipped_x9", xreg(9), 32'h0);
        checkOutput("skipped_x10", xreg(10), 32'h0);
        checkOutput("fallthrough_x8", xreg(8), 32'h2);

        applyStimulus(13);
        checkOutput("ecall_fetch_pc", dut.top.pc, 32'h70);
        checkOutput("lui_addi_x11", xreg(11), 32'h80FF_7F01);
        checkOutput("lb_x13", xreg(13), 32'h0000_0001);
        checkOutput("lb_x14", xreg(14), 32'hFFFF_FF80);
        checkOutput("lbu_x15", xreg(15), 32'h0000_0080);
        checkOutput("lh_x16", xreg(16), 32'hFFFF_80FF);
        checkOutput("lhu_x17", xreg(17), 32'h0000_80FF);
        checkOutput("sb_lw_x19", xreg(19), 32'h80FF_2201);
        checkOutput("lh_misaligned_x22", xreg(22), 32'h0000_2201);
        applyStimulus(1);
        checkOutput("ecall_next_pc", dut.top.pc, 32'h74);
        applyStimulus(1);
        checkOutput("csrrw_next_pc", dut.top.pc, 32'h78);
        checkOutput("csrrw_no_rd_x20", xreg(20), 32'h0);
        checkOutput("csrrw_x1_kept", xreg(1), 32'hFFFF_FFFF);
        applyStimulus(1);
        checkOutput("after_nops_x21", xreg(21), 32'h7);
        applyStimulus(3);
        checkOutput("self_loop_pc", dut.top.pc, 32'h7C);

        // Program B: jalr compliance-style test with rd == rs1 and an odd target.
        prog = '{
            enc_i(12'd2, 5'd0, F3_ADD, 5'd3, OPC_OP_IMM),         // 00 x3 = test 2
            enc_u(20'h0, 5'd7, OPC_AUIPC),                        // 04 x7 = 4
            enc_i(12'd17, 5'd7, 3'b000, 5'd7, OPC_JALR),          // 08 JALR x7,x7,17 -> 0x14
            enc_i(12'd0, 5'd0, F3_ADD, 5'd27, OPC_OP_IMM),        // 0C
            enc_i(12'd0, 5'd0, F3_ADD, 5'd27, OPC_OP_IMM),        // 10
            enc_i(12'h00C, 5'd0, F3_ADD, 5'd8, OPC_OP_IMM),       // 14 x8 = 0x0C
            enc_b(13'd12, 5'd8, 5'd7, F3_BNE),                    // 18 BNE x7,x8 -> fail
            enc_i(12'd1, 5'd0, F3_ADD, 5'd27, OPC_OP_IMM),        // 1C x27 = 1
            enc_j(21'd8, 5'd0),                                   // 20 -> 0x28
            enc_i(12'd0, 5'd0, F3_ADD, 5'd27, OPC_OP_IMM),        // 24 fail path
            enc_i(12'd1, 5'd0, F3_ADD, 5'd26, OPC_OP_IMM),        // 28 x26 = 1
            enc_j(21'd0, 5'd0)                                    // 2C halt
        };
        loadProgram();
        resetDut();
        for (int i = 1; i < 32; i++)
            checkOutput($sformatf("reset_clear_x%0d", i), xreg(i), 32'h0);
        for (cycles = 0; cycles < 200 && xreg(26) != 32'h1; cycles++)
            applyStimulus(1);
        checkOutput("sig_x26_done", xreg(26), 32'h1);
        #200;
        checkOutput("sig_x27_pass", xreg(27), 32'h1);
        checkOutput("sig_x3_testnum", xreg(3), 32'h2);
        checkOutput("jalr_rd_eq_rs1_x7", xreg(7), 32'h0C);

        // Program C: jump past the ROM depth, which must fetch NOPs.
        prog = '{
            enc_u(20'h00010, 5'd1, OPC_LUI),                      // 00 x1 = 0x10000
            enc_i(12'd0, 5'd1, 3'b000, 5'd2, OPC_JALR)            // 04 JALR x2,x1,0
        };
        loadProgram();
        resetDut();
        applyStimulus(2);
        checkOutput("beyond_rom_pc", dut.top.pc, 32'h0001_0000);
        checkOutput("beyond_rom_instr", dut.top.instr, NOP);
        checkOutput("beyond_rom_link_x2", xreg(2), 32'h8);
        applyStimulus(1);
        checkOutput("beyond_rom_next_pc", dut.top.pc, 32'h0001_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
